// File: rtl/bm_lpm_split.sv
// Receive-side deframer: checks the constant header on each framed word, strips it,
// and queues the payload in a 2-entry FIFO; mismatched words are dropped and counted.
module bm_lpm_split #(
    parameter int               BITS   = 32,
    parameter int               HDR_W  = 8,
    parameter logic [HDR_W-1:0] HEADER = 8'h56,
    parameter int               CNT_W  = 16
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BITS-1:0]       in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BITS-HDR_W-1:0] out_data,
    input  logic                  clear_counts,
    output logic [CNT_W-1:0]      good_count,
    output logic [CNT_W-1:0]      err_count,
    output logic                  err_flag
);
    localparam int PAY_W = BITS - HDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PAY_W-1:0] mem_reg [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic [1:0]       count_next;
    logic [CNT_W-1:0] good_count_reg;
    logic [CNT_W-1:0] err_count_reg;
    logic             err_flag_reg;

    logic accept;
    logic hdr_ok;
    logic push;
    logic drop;
    logic pop;

    // Handshake status depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count_reg < 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign out_data  = mem_reg[rd_ptr_reg];

    assign accept = in_valid & in_ready;
    assign hdr_ok = (in_data[BITS-1 -: HDR_W] == HEADER);
    assign push   = accept & hdr_ok;
    assign drop   = accept & ~hdr_ok;
    assign pop    = out_valid & out_ready;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == gi[0])) begin
                    mem_reg[gi] <= in_data[PAY_W-1:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_next;
        end
    end

    // A clear in the same cycle as an event discards that event.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            good_count_reg <= '0;
            err_count_reg  <= '0;
            err_flag_reg   <= 1'b0;
        end else if (clear_counts) begin
            good_count_reg <= '0;
            err_count_reg  <= '0;
            err_flag_reg   <= 1'b0;
        end else begin
            if (push && (good_count_reg != CNT_MAX)) good_count_reg <= good_count_reg + 1'b1;
            if (drop && (err_count_reg != CNT_MAX))  err_count_reg  <= err_count_reg + 1'b1;
            if (drop) err_flag_reg <= 1'b1;
        end
    end

    assign good_count = good_count_reg;
    assign err_count  = err_count_reg;
    assign err_flag   = err_flag_reg;
endmodule

// File: tb/tb_bm_lpm_split.sv
// Directed bench for bm_lpm_split: payload order checked against a queue of expected
// payloads; a second instance with 2-bit counters exercises saturation.
module tb_bm_lpm_split;
    logic        clock;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        clear_counts;
    logic [15:0] good_count;
    logic [15:0] err_count;
    logic        err_flag;

    logic        in_ready2;
    logic        out_valid2;
    logic [23:0] out_data2;
    logic [1:0]  good_count2;
    logic [1:0]  err_count2;
    logic        err_flag2;

    int total = 0;
    int bad   = 0;
    int pops  = 0;
    int pops_before;
    logic [23:0] sb[$];
    logic [23:0] exp_p;

    bm_lpm_split dut (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .clear_counts(clear_counts),
        .good_count(good_count), .err_count(err_count), .err_flag(err_flag)
    );

    bm_lpm_split #(.CNT_W(2)) dut2 (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .clear_counts(clear_counts),
        .good_count(good_count2), .err_count(err_count2), .err_flag(err_flag2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: expected payloads pushed at accepted good words, popped at output handshakes.
    always @(negedge clock) begin
        if (resetn) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL sb_underflow: observed=%0h expected=none", out_data);
                end else begin
                    exp_p = sb.pop_front();
                    pops++;
                    chk("sb_data", {8'h0, out_data}, {8'h0, exp_p});
                end
            end
            if (in_valid && in_ready && (in_data[31:24] == 8'h56))
                sb.push_back(in_data[23:0]);
        end
    end

    initial begin
        resetn = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear_counts = 1'b0;
        #1 resetn = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_good", good_count, 0);
        chk("rst_err", err_count, 0);
        chk("rst_flag", err_flag, 0);
        repeat (2) tick();
        resetn = 1'b1;

        // single good word
        in_valid = 1'b1; in_data = 32'h56ABCDEF; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clock);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_data", out_data, 32'hABCDEF);
        chk("t1_good", good_count, 1);
        chk("t1_flag", err_flag, 0);
        tick();

        // bad header, then clear
        in_valid = 1'b1; in_data = 32'h57000001;
        tick();
        in_valid = 1'b0;
        @(negedge clock);
        chk("t2_out_valid", out_valid, 0);
        chk("t2_err", err_count, 1);
        chk("t2_flag", err_flag, 1);
        chk("t2_good", good_count, 1);
        tick();
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        @(negedge clock);
        chk("t2_clr_err", err_count, 0);
        chk("t2_clr_flag", err_flag, 0);
        chk("t2_clr_good", good_count, 0);
        tick();

        // backpressure and order
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h56000001;
        tick();
        in_data = 32'h56000002;
        tick();
        in_data = 32'h56000003;
        @(negedge clock);
        chk("t3_full_ready", in_ready, 0);
        chk("t3_head", out_data, 32'h000001);
        tick();
        @(negedge clock);
        chk("t3_hold_ready", in_ready, 0);
        chk("t3_hold_data", out_data, 32'h000001);
        tick();
        out_ready = 1'b1;
        tick();
        @(negedge clock);
        chk("t3_ready_back", in_ready, 1);
        chk("t3_second", out_data, 32'h000002);
        tick();
        in_valid = 1'b0;
        @(negedge clock);
        chk("t3_third", out_data, 32'h000003);
        chk("t3_third_valid", out_valid, 1);
        tick();
        @(negedge clock);
        chk("t3_empty", out_valid, 0);
        chk("t3_good", good_count, 3);
        tick();

        // streaming
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        pops_before = pops;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 32'h56000100 + i;
            @(negedge clock);
            chk("t4_in_ready", in_ready, 1);
            if (i > 0) chk("t4_latency", out_valid, 1);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clock);
        chk("t4_last_data", out_data, 32'h000109);
        tick();
        @(negedge clock);
        chk("t4_pops", pops - pops_before, 10);
        chk("t4_good", good_count, 10);
        tick();

        // counter saturation (dut2 has 2-bit counters)
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 32'h11000000 + i;
            tick();
        end
        in_valid = 1'b0;
        @(negedge clock);
        chk("t5_err_sat", err_count2, 3);
        chk("t5_err_wide", err_count, 5);
        chk("t5_flag", err_flag2, 1);
        chk("t5_no_out", out_valid, 0);
        tick();
        clear_counts = 1'b1; in_valid = 1'b1; in_data = 32'h22000000;
        tick();
        clear_counts = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        chk("t5_clr_err2", err_count2, 0);
        chk("t5_clr_err", err_count, 0);
        chk("t5_clr_flag", err_flag, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 32'h56000200 + i;
            tick();
        end
        in_valid = 1'b0;
        tick();
        @(negedge clock);
        chk("t5_good_sat", good_count2, 3);
        chk("t5_good_wide", good_count, 5);
        tick();

        // asynchronous reset with a full FIFO
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h560000A1;
        tick();
        in_data = 32'h560000A2;
        tick();
        in_valid = 1'b0;
        #1;
        chk("t6_pre_valid", out_valid, 1);
        chk("t6_pre_ready", in_ready, 0);
        #1 resetn = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_ready", in_ready, 1);
        chk("t6_rst_good", good_count, 0);
        chk("t6_rst_err", err_count, 0);
        chk("t6_rst_flag", err_flag, 0);
        chk("t6_rst_data", out_data, 0);
        sb.delete();
        @(negedge clock);
        #1 resetn = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("t6_no_stale", out_valid, 0);
        end
        tick();
        in_valid = 1'b1; in_data = 32'h560000B7;
        tick();
        in_valid = 1'b0;
        @(negedge clock);
        chk("t6_after_data", out_data, 32'h0000B7);
        chk("t6_after_good", good_count, 1);
        tick();
        tick();
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
